recip_share_arbiter: RTL and testbench
======================================

# recip_share_arbiter

Shares one combinational reciprocal lookup among N_REQ requesters in the camera pipeline, such as the per-colour centroid units that divide coordinate sums by pixel counts. Each requester submits a numerator/denominator pair over a valid/ready handshake. The block grants requesters round-robin, drives the lookup address, and multiplies the numerator by the returned Q1.23 reciprocal. It returns the quotient to the granted requester over a second valid/ready handshake. One division is in flight at a time.

## Interface
- N_REQ, 3, number of requesters (2..8)
- WIDTH_IN, 17, denominator width; matches the lookup input
- WIDTH_OUT, 24, reciprocal width, Q1.23 (0x800000 = 1.0)
- NUM_W, 26, numerator and quotient width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester grant/accept, one-hot or zero
- req_num  in  N_REQ*NUM_W  packed numerators; requester i at [i*NUM_W +: NUM_W]
- req_den  in  N_REQ*WIDTH_IN  packed denominators, same packing
- rsp_valid  out  N_REQ  per-requester response valid, one-hot or zero
- rsp_ready  in  N_REQ  per-requester response accept
- rsp_quot  out  NUM_W  quotient, shared bus; valid only with rsp_valid
- recip_x  out  WIDTH_IN  registered lookup address, to the lookup x input
- recip_y  in  WIDTH_OUT  lookup result, combinational from recip_x
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, LOOKUP, MULT, RESP.
- **IDLE**
  - Select the first i with req_valid[i] high, searching from last_grant+1 modulo N_REQ.
  - Assert req_ready[i] combinationally in that same cycle.
  - Latch num_reg, den_reg and owner=i; set last_grant=i; go to LOOKUP.
  - If no request is valid, stay in IDLE.
- **LOOKUP**
  - recip_x = den_reg, which has been registered since the grant edge.
  - At the end of the cycle, register y_reg = min(recip_y, 0x800000); go to MULT.
- **MULT**
  - prod = num_reg * y_reg, unsigned, NUM_W+WIDTH_OUT bits.
  - quot_reg = prod >> 23, truncated to NUM_W; go to RESP.
  - The clamp guarantees quot ≤ num, so truncation never loses bits.
- **RESP**
  - rsp_valid[owner]=1 and rsp_quot=quot_reg, both held stable.
  - When rsp_ready[owner]=1, complete the transfer and return to IDLE.
  - rsp_ready bits of non-owners are ignored.
- Only requester owner can receive rsp_valid. req_ready is zero outside IDLE.
- A requester may deassert req_valid at any time before it is granted.
- recip_x holds the last den_reg between operations.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_quot=0, recip_x=0, busy=0, state=IDLE, last_grant=N_REQ-1 (requester 0 wins first).
- Latency and throughput:
  - Cycle 0: grant (IDLE).
  - Cycle 1: LOOKUP.
  - Cycle 2: MULT.
  - Cycle 3: rsp_valid first high.
  - Minimum 4 cycles per division when rsp_ready is already high. The next grant can occur in the cycle after the response handshake.
- Backpressure: while rsp_ready[owner]=0, state stays RESP, outputs are unchanged, and no grant is issued.
- Simultaneous requests: the round-robin order guarantees that no requester waits more than N_REQ-1 other grants.
- Reset during any state aborts the operation. The pending response is never delivered and all outputs take their reset values asynchronously.
- rsp_quot is registered. recip_x is registered. req_ready is combinational from req_valid and the state.

## Configuration
- Macro RECIP_ARB_DIV0_EN.
- Defined:
  - Adds output rsp_div0 (1 bit, reset 0).
  - A granted request with den==0 sets div0_reg, forces quot_reg=0, and still passes through all states with the same latency.
  - rsp_div0 is valid alongside rsp_valid.
- Undefined:
  - No rsp_div0 port.
  - den==0 is handled by the lookup's own rule (y=0x800000), so quot=num.

## Test plan
- **Single request:** num=1000, den=1, recip_y model returns 0x800000; rsp_ready high.
  - req_ready[0] high in cycle 0.
  - rsp_valid[0] high in cycle 3 with rsp_quot=1000.
- **Ratio:** num=76800, den=300, model y=0x006D3A (≈2^23/300).
  - rsp_quot=(76800*0x6D3A)>>23=255.
- **Round-robin:** all three req_valid held high for 4 operations.
  - Grant order 0,1,2,0.
  - req_ready is never multi-hot.
  - Each rsp_valid goes to the matching requester.
- **Backpressure:** rsp_ready[1] low for 5 cycles during RESP.
  - rsp_valid[1] and rsp_quot are stable for all 5 cycles.
  - req_ready stays 0 despite other req_valid.
  - Handshake completes on the 6th cycle.
- **Clamp:** recip_y forced to 0xFFFFFF, num=10.
  - rsp_quot=10.
- **Reset mid-operation:** rst_n low during MULT.
  - All outputs are 0 immediately.
  - After release, no stale rsp_valid appears and requester 0 wins the first grant.
  - With RECIP_ARB_DIV0_EN defined: den=0, num=55 gives rsp_div0=1 and rsp_quot=0.

Source files
------------

// File: rtl/recip_share_arbiter.sv
// Round-robin share of one combinational Q1.23 reciprocal lookup; one division in flight.
// Optional RECIP_ARB_DIV0_EN adds a divide-by-zero flag (rsp_div0) and forces quot=0 for den==0.
module recip_share_arbiter #(
  parameter int N_REQ     = 3,
  parameter int WIDTH_IN  = 17,
  parameter int WIDTH_OUT = 24,
  parameter int NUM_W     = 26
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*NUM_W-1:0]    req_num,
  input  logic [N_REQ*WIDTH_IN-1:0] req_den,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [NUM_W-1:0]          rsp_quot,
  output logic [WIDTH_IN-1:0]       recip_x,
  input  logic [WIDTH_OUT-1:0]      recip_y,
`ifdef RECIP_ARB_DIV0_EN
  output logic                      rsp_div0,
`endif
  output logic                      busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [WIDTH_OUT-1:0] ONE = {1'b1, {(WIDTH_OUT-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOOKUP, MULT, RESP} state_t;

  state_t                         state;
  logic [IW-1:0]                  owner;     // also serves as last_grant
  logic [NUM_W-1:0]               num_reg;
  logic [WIDTH_IN-1:0]            den_reg;
  logic [WIDTH_OUT-1:0]           y_reg;
  logic [NUM_W-1:0]               quot_reg;
  logic [N_REQ-1:0][NUM_W-1:0]    num_a;
  logic [N_REQ-1:0][WIDTH_IN-1:0] den_a;
  logic [NUM_W+WIDTH_OUT-1:0]     prod;
  logic [NUM_W-1:0]               quot_w;
  logic                           gnt_found;
  logic [IW-1:0]                  gnt_idx;
`ifdef RECIP_ARB_DIV0_EN
  logic                           div0_reg;
`endif

  assign num_a = req_num;
  assign den_a = req_den;

  // Walk from farthest to nearest so the candidate closest after owner wins.
  always_comb begin
    int c;
    logic [IW-1:0] cidx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    c         = 0;
    cidx      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      c = int'(owner) + k;
      if (c >= N_REQ) c = c - N_REQ;
      cidx = IW'(c);
      if (req_valid[cidx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cidx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  // Clamp keeps y <= 1.0, so the quotient never exceeds the numerator.
  assign prod   = {{WIDTH_OUT{1'b0}}, num_reg} * {{NUM_W{1'b0}}, y_reg};
  assign quot_w = NUM_W'(prod >> (WIDTH_OUT-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= IW'(N_REQ-1);
      num_reg   <= '0;
      den_reg   <= '0;
      y_reg     <= '0;
      quot_reg  <= '0;
      rsp_valid <= '0;
`ifdef RECIP_ARB_DIV0_EN
      div0_reg  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (gnt_found) begin
          num_reg  <= num_a[gnt_idx];
          den_reg  <= den_a[gnt_idx];
          owner    <= gnt_idx;
`ifdef RECIP_ARB_DIV0_EN
          div0_reg <= (den_a[gnt_idx] == '0);
`endif
          state    <= LOOKUP;
        end
        LOOKUP: begin
          y_reg <= (recip_y > ONE) ? ONE : recip_y;
          state <= MULT;
        end
        MULT: begin
`ifdef RECIP_ARB_DIV0_EN
          quot_reg <= div0_reg ? '0 : quot_w;
`else
          quot_reg <= quot_w;
`endif
          rsp_valid <= N_REQ'(1) << owner;
          state     <= RESP;
        end
        RESP: if (rsp_ready[owner]) begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_quot = quot_reg;
  assign recip_x  = den_reg;
  assign busy     = (state != IDLE);
`ifdef RECIP_ARB_DIV0_EN
  assign rsp_div0 = div0_reg;
`endif

endmodule

// File: tb/tb_recip_share_arbiter.sv
// Directed bench for recip_share_arbiter; recip_y comes from an ideal 2^23/x lookup model.
module tb_recip_share_arbiter;
  localparam int N_REQ = 3, WIDTH_IN = 17, WIDTH_OUT = 24, NUM_W = 26;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [N_REQ-1:0]          req_valid = '0;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ*NUM_W-1:0]    req_num = '0;
  logic [N_REQ*WIDTH_IN-1:0] req_den = '0;
  logic [N_REQ-1:0]          rsp_valid;
  logic [N_REQ-1:0]          rsp_ready = '0;
  logic [NUM_W-1:0]          rsp_quot;
  logic [WIDTH_IN-1:0]       recip_x;
  logic [WIDTH_OUT-1:0]      recip_y;
  logic                      busy;
`ifdef RECIP_ARB_DIV0_EN
  logic                      rsp_div0;
`endif
  logic                      y_force = 1'b0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    if (y_force)           recip_y = 24'hFFFFFF;
    else if (recip_x == 0) recip_y = 24'h800000;
    else                   recip_y = 24'(24'h800000 / recip_x);
  end

  recip_share_arbiter #(.N_REQ(N_REQ), .WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT), .NUM_W(NUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_num(req_num), .req_den(req_den), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quot(rsp_quot), .recip_x(recip_x), .recip_y(recip_y),
`ifdef RECIP_ARB_DIV0_EN
    .rsp_div0(rsp_div0),
`endif
    .busy(busy));

  task automatic set_req(input int i, input int num, input int den);
    req_num[i*NUM_W +: NUM_W]       = NUM_W'(num);
    req_den[i*WIDTH_IN +: WIDTH_IN] = WIDTH_IN'(den);
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    n_chk++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 000", req_ready); end
    n_chk++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 000", rsp_valid); end
    n_chk++; if (rsp_quot !== '0) begin n_fail++; $display("FAIL reset_rsp_quot: got %0d want 0", rsp_quot); end
    n_chk++; if (recip_x !== '0) begin n_fail++; $display("FAIL reset_recip_x: got %0d want 0", recip_x); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef RECIP_ARB_DIV0_EN
    n_chk++; if (rsp_div0 !== 1'b0) begin n_fail++; $display("FAIL reset_div0: got %b want 0", rsp_div0); end
`endif
    rsp_ready = 3'b111;
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single;
    @(negedge clk); set_req(0, 1000, 1); req_valid = 3'b001; #1;
    n_chk++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL single_grant: got %b want 001", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    n_chk++; if (recip_x !== 17'd1) begin n_fail++; $display("FAIL single_recip_x: got %0d want 1", recip_x); end
    @(negedge clk); #1;
    n_chk++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL single_early_rsp: got %b want 000", rsp_valid); end
    @(negedge clk); #1;
    n_chk++; if (rsp_valid !== 3'b001) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 001", rsp_valid); end
    n_chk++; if (rsp_quot !== 26'd1000) begin n_fail++; $display("FAIL single_quot: got %0d want 1000", rsp_quot); end
    @(negedge clk); #1;
    n_chk++; if (busy !== 1'b0 || rsp_valid !== 3'b000) begin n_fail++; $display("FAIL single_done: busy %b rsp_valid %b want 0 000", busy, rsp_valid); end
  endtask

  task automatic test_ratio;
    @(negedge clk); set_req(0, 76800, 300); req_valid = 3'b001; #1;
    n_chk++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL ratio_grant: got %b want 001", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    n_chk++; if (recip_x !== 17'd300) begin n_fail++; $display("FAIL ratio_recip_x: got %0d want 300", recip_x); end
    @(negedge clk);
    @(negedge clk); #1;
    n_chk++; if (rsp_valid !== 3'b001) begin n_fail++; $display("FAIL ratio_rsp_valid: got %b want 001", rsp_valid); end
    n_chk++; if (rsp_quot !== 26'd255) begin n_fail++; $display("FAIL ratio_quot: got %0d want 255", rsp_quot); end
  endtask

  task automatic test_round_robin;
    for (int op = 0; op < 4; op++) begin
      int exp;
      exp = op % 3;
      @(negedge clk);
      if (op == 0) begin
        rst_n = 1'b0; #1; rst_n = 1'b1;
        set_req(0, 100, 1); set_req(1, 200, 1); set_req(2, 300, 1);
        req_valid = 3'b111;
      end
      #1;
      n_chk++; if (req_ready !== 3'(1 << exp)) begin n_fail++; $display("FAIL rr_grant op%0d: got %b want %b", op, req_ready, 3'(1 << exp)); end
      n_chk++; if (!$onehot(req_ready)) begin n_fail++; $display("FAIL rr_onehot op%0d: got %b", op, req_ready); end
      for (int c = 1; c < 3; c++) begin
        @(negedge clk); #1;
        n_chk++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL rr_ready_busy op%0d: got %b want 000", op, req_ready); end
      end
      @(negedge clk); #1;
      n_chk++; if (rsp_valid !== 3'(1 << exp)) begin n_fail++; $display("FAIL rr_rsp_valid op%0d: got %b want %b", op, rsp_valid, 3'(1 << exp)); end
      n_chk++; if (rsp_quot !== NUM_W'((exp + 1) * 100)) begin n_fail++; $display("FAIL rr_quot op%0d: got %0d want %0d", op, rsp_quot, (exp + 1) * 100); end
    end
    @(negedge clk); req_valid = '0;
  endtask

  task automatic test_backpressure;
    @(negedge clk); set_req(1, 500, 1); req_valid = 3'b010; rsp_ready = 3'b101; #1;
    n_chk++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL bp_grant: got %b want 010", req_ready); end
    @(negedge clk); req_valid = 3'b101;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_chk++; if (rsp_valid !== 3'b010) begin n_fail++; $display("FAIL bp_rsp_valid c%0d: got %b want 010", c, rsp_valid); end
      n_chk++; if (rsp_quot !== 26'd500) begin n_fail++; $display("FAIL bp_quot c%0d: got %0d want 500", c, rsp_quot); end
      n_chk++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL bp_req_ready c%0d: got %b want 000", c, req_ready); end
    end
    @(negedge clk); rsp_ready = 3'b111; #1;
    n_chk++; if (rsp_valid !== 3'b010) begin n_fail++; $display("FAIL bp_sixth: got %b want 010", rsp_valid); end
    @(negedge clk); #1;
    n_chk++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL bp_released: got %b want 000", rsp_valid); end
    n_chk++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL bp_next_grant: got %b want 100", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_clamp;
    @(negedge clk); y_force = 1'b1; set_req(2, 10, 7); req_valid = 3'b100; #1;
    n_chk++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL clamp_grant: got %b want 100", req_ready); end
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk); #1;
    n_chk++; if (rsp_valid !== 3'b100) begin n_fail++; $display("FAIL clamp_rsp_valid: got %b want 100", rsp_valid); end
    n_chk++; if (rsp_quot !== 26'd10) begin n_fail++; $display("FAIL clamp_quot: got %0d want 10", rsp_quot); end
    @(negedge clk); y_force = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk); set_req(0, 1234, 3); req_valid = 3'b001; #1;
    n_chk++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rmid_grant: got %b want 001", req_ready); end
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1; rst_n = 1'b0; req_valid = 3'b010; #1;
    n_chk++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL rmid_rsp_valid: got %b want 000", rsp_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_chk++; if (recip_x !== '0) begin n_fail++; $display("FAIL rmid_recip_x: got %0d want 0", recip_x); end
    n_chk++; if (rsp_quot !== '0) begin n_fail++; $display("FAIL rmid_quot: got %0d want 0", rsp_quot); end
    n_chk++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL rmid_req_ready: got %b want 000", req_ready); end
    @(negedge clk); rst_n = 1'b1; req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_chk++; if (rsp_valid !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_stale c%0d: rsp_valid %b busy %b want 000 0", c, rsp_valid, busy); end
    end
    @(negedge clk); set_req(1, 1, 1); set_req(2, 2, 1); req_valid = 3'b111; #1;
    n_chk++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rmid_first_grant: got %b want 001", req_ready); end
    req_valid = '0;
    repeat (4) @(negedge clk);
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_drain: got %b want 0", busy); end
  endtask

  task automatic test_div0;
    @(negedge clk); set_req(1, 55, 0); req_valid = 3'b010; #1;
    n_chk++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL div0_grant: got %b want 010", req_ready); end
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk); #1;
    n_chk++; if (rsp_valid !== 3'b010) begin n_fail++; $display("FAIL div0_rsp_valid: got %b want 010", rsp_valid); end
`ifdef RECIP_ARB_DIV0_EN
    n_chk++; if (rsp_quot !== 26'd0) begin n_fail++; $display("FAIL div0_quot: got %0d want 0", rsp_quot); end
    n_chk++; if (rsp_div0 !== 1'b1) begin n_fail++; $display("FAIL div0_flag: got %b want 1", rsp_div0); end
`else
    n_chk++; if (rsp_quot !== 26'd55) begin n_fail++; $display("FAIL div0_quot: got %0d want 55", rsp_quot); end
`endif
    @(negedge clk); #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL div0_done: got %b want 0", busy); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_ratio;
    test_round_robin;
    test_backpressure;
    test_clamp;
    test_reset_mid;
    test_div0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
